// File: rtl/rv0_pkg.sv
// Shared types and constants for the rv0 fetch stage.
package rv0_pkg;

    localparam int unsigned RV0_XLEN = 32;
    localparam logic [31:0] RV0_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [RV0_XLEN-1:0] addr;
        logic [31:0]         insn;
        logic                err;
    } fetch_entry_t;

endpackage

// File: rtl/rv0_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with clear, push, pop and occupancy count.
module rv0_fetch_fifo
    import rv0_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + ONE;
            if (pop)  rptr <= rptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear && !rst) mem[wptr[AW-1:0]] <= wdata;
    end

    assign count = wptr - rptr;
    assign empty = (count == '0);
    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/rv0_fetch.sv
// Instruction fetch stage: PC, imem request/response tracking, fetch queue, redirect handling.
// Optional performance counters enabled by defining RV0_FETCH_PERF_EN.
module rv0_fetch
    import rv0_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int unsigned     QDEPTH     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_addr_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    output logic [XLEN-1:0] addr_o,
    output logic [31:0]     insn_o,
    output logic            err_o,
    output logic            rdy_o,
    input  logic            ack_i
`ifdef RV0_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_o,
    output logic [31:0]     perf_empty_o
`endif
);

    localparam int unsigned     CW         = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0]   ONE        = CW'(1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, resp_pc, stale_addr;
    logic            pending, stale;
    logic [CW-1:0]   outstanding, outstanding_n, discard, count;
    logic [CW:0]     used;
    logic            credit, fire, discard_hit, push, pop, resp_err, empty;
    fetch_entry_t    head, wdata;

    rv0_fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

    assign rdy_o  = !empty;
    assign addr_o = empty ? '0 : head.addr;
    assign insn_o = empty ? RV0_NOP : head.insn;
    assign err_o  = !empty && head.err;
    assign wdata  = '{addr: resp_pc, insn: imem_rdata_i, err: imem_err_i};

    always_comb begin
        pop         = rdy_o && ack_i && !flush_i;
        // Slot freed by this cycle's pop counts as credit, so QDEPTH=2 sustains one fetch per cycle.
        used        = (CW+1)'(count) + (CW+1)'(outstanding) - (CW+1)'(pop);
        credit      = used < (CW+1)'(QDEPTH);
        imem_req_o  = stale || pending || (state == RUN && credit);
        imem_addr_o = stale ? stale_addr : pc;
        fire        = imem_req_o && imem_gnt_i;
        discard_hit = imem_rvalid_i && (discard != '0);
        push        = imem_rvalid_i && !discard_hit && !flush_i;
        resp_err    = imem_rvalid_i && imem_err_i && !discard_hit;
        outstanding_n = outstanding + (fire ? ONE : '0) - (imem_rvalid_i ? ONE : '0);

        state_n = state;
        unique case (state)
            BOOT:    state_n = RUN;
            RUN:     if (resp_err) state_n = HALT;
            HALT:    state_n = HALT;
            default: state_n = BOOT;
        endcase
        if (flush_i) state_n = RUN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= BOOT;
            pc          <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            stale_addr  <= RESET_ADDR;
            stale       <= 1'b0;
            pending     <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_n;
            outstanding <= outstanding_n;
            if (flush_i) begin
                // An ungranted request keeps its address across the redirect; its response is discarded.
                pc         <= flush_addr_i & ALIGN_MASK;
                resp_pc    <= flush_addr_i & ALIGN_MASK;
                discard    <= outstanding_n;
                pending    <= 1'b0;
                stale      <= imem_req_o && !imem_gnt_i;
                stale_addr <= imem_addr_o;
            end else begin
                if (fire && !stale) pc <= pc + STEP;
                if (push) resp_pc <= resp_pc + STEP;
                discard <= discard + ((fire && stale) ? ONE : '0) - (discard_hit ? ONE : '0);
                pending <= imem_req_o && !imem_gnt_i && !stale;
                if (fire) stale <= 1'b0;
            end
        end
    end

`ifdef RV0_FETCH_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_o <= '0;
            perf_empty_o <= '0;
        end else begin
            if (rdy_o && !ack_i)          perf_stall_o <= perf_stall_o + 32'd1;
            if (state == RUN && !rdy_o)   perf_empty_o <= perf_empty_o + 32'd1;
        end
    end
`endif

endmodule
